fetch_stage: RTL and testbench

//  IF stage of the 5-stage pipelined CPU: owns the PC register, drives instruction-memory address,
//  and holds the IF/ID pipeline register consumed by decode/Registers/Control/Hazard_Detection.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_sat_counter.sv | 34 +++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: datapath width, bubble word and FSM encoding.
package fetch_stage_pkg;

   localparam int unsigned PC_W = 32;
   localparam logic [PC_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [PC_W-1:0] PC_STEP = 32'd4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   // Branch targets are word aligned; the low two bits from the ID adder are dropped.
   function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, IF/ID pipeline register, IDLE/RUN control and stall/flush statistics.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = 32'h0,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             pc_write_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [31:0]      branch_target_i,
   input  logic [31:0]      imem_data_i,
   output logic [31:0]      imem_addr_o,
   output logic [31:0]      pc_o,
   output logic [31:0]      if_id_pc_o,
   output logic [31:0]      if_id_instr_o,
   output logic             if_id_valid_o,
   output logic [CNT_W-1:0] stall_count_o,
   output logic [CNT_W-1:0] flush_count_o,
   output logic             state_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  if_id_pc_q, if_id_pc_d;
   logic [31:0]  if_id_instr_q, if_id_instr_d;
   logic         if_id_valid_q, if_id_valid_d;
   logic         active;
   logic         stall_inc;
   logic         flush_inc;

   // Control priority each active cycle: flush redirects and squashes regardless of the
   // hazard inputs; otherwise any stall request (pc_write_i low or stall_i high) freezes
   // PC and IF/ID; otherwise the word at pc is latched into IF/ID and pc advances.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      active        = (state_q == RUN) || start_i;

      if (active) begin
         state_d = RUN;
         if (flush_i) begin
            pc_d          = align_word(branch_target_i);
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            flush_inc     = 1'b1;
         end else if (!pc_write_i || stall_i) begin
            stall_inc = 1'b1;
         end else begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_data_i;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + PC_STEP;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         pc_q          <= PC_RESET;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (1'b0),
      .inc_i   (stall_inc),
      .count_o (stall_count_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (1'b0),
      .inc_i   (flush_inc),
      .count_o (flush_count_o)
   );

   assign imem_addr_o   = pc_q;
   assign pc_o          = pc_q;
   assign if_id_pc_o    = if_id_pc_q;
   assign if_id_instr_o = if_id_instr_q;
   assign if_id_valid_o = if_id_valid_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;

   localparam int          CNT_W   = 3;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic             clk_i = 1'b0;
   logic             rst_i, start_i, pc_write_i, stall_i, flush_i;
   logic [31:0]      branch_target_i, imem_data_i, imem_addr_o, pc_o;
   logic [31:0]      if_id_pc_o, if_id_instr_o;
   logic             if_id_valid_o, state_o;
   logic [CNT_W-1:0] stall_count_o, flush_count_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic        m_run;
   logic [31:0] m_pc, m_ifpc, m_instr;
   logic        m_valid;
   int          m_stall, m_flush;

   always #5 clk_i = ~clk_i;

   fetch_stage #(.PC_RESET(32'h0), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_write_i(pc_write_i),
      .stall_i(stall_i), .flush_i(flush_i), .branch_target_i(branch_target_i),
      .imem_data_i(imem_data_i), .imem_addr_o(imem_addr_o), .pc_o(pc_o),
      .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
      .stall_count_o(stall_count_o), .flush_count_o(flush_count_o), .state_o(state_o)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_data_i = word_at(imem_addr_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic start, input logic pcw,
                             input logic stl, input logic fl, input logic [31:0] tgt);
      if (rst) begin
         m_run = 0; m_pc = 32'h0; m_ifpc = 0; m_instr = NOP; m_valid = 0;
         m_stall = 0; m_flush = 0;
      end else if (m_run || start) begin
         m_run = 1;
         if (fl) begin
            m_pc = tgt & ~32'h3;
            m_ifpc = 0; m_instr = NOP; m_valid = 0;
            if (m_flush < CNT_MAX) m_flush++;
         end else if (!pcw || stl) begin
            if (m_stall < CNT_MAX) m_stall++;
         end else begin
            m_ifpc = m_pc; m_instr = word_at(m_pc); m_valid = 1;
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_state"}, {31'b0, state_o}, {31'b0, m_run});
      chk({tag, "_pc"}, pc_o, m_pc);
      chk({tag, "_imem_addr"}, imem_addr_o, m_pc);
      chk({tag, "_if_id_pc"}, if_id_pc_o, m_ifpc);
      chk({tag, "_if_id_instr"}, if_id_instr_o, m_instr);
      chk({tag, "_valid"}, {31'b0, if_id_valid_o}, {31'b0, m_valid});
      chk({tag, "_stall_cnt"}, 32'(stall_count_o), 32'(m_stall));
      chk({tag, "_flush_cnt"}, 32'(flush_count_o), 32'(m_flush));
   endtask

   task automatic cycle(input string tag, input logic rst, input logic start, input logic pcw,
                        input logic stl, input logic fl, input logic [31:0] tgt);
      @(negedge clk_i);
      rst_i = rst; start_i = start; pc_write_i = pcw; stall_i = stl; flush_i = fl;
      branch_target_i = tgt;
      @(posedge clk_i);
      model_step(rst, start, pcw, stl, fl, tgt);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_i = 1; start_i = 0; pc_write_i = 1; stall_i = 0; flush_i = 0; branch_target_i = 0;
      model_step(1, 0, 1, 0, 0, 0);

      // Reset state, then IDLE ignores every input
      cycle("rst", 1, 0, 1, 0, 0, 0);
      cycle("rst2", 1, 1, 1, 1, 1, 32'h80);
      chk("rst_pc_const", pc_o, 32'h0);
      chk("rst_instr_const", if_id_instr_o, NOP);
      cycle("idle_a", 0, 0, 1, 0, 1, 32'h80);
      cycle("idle_b", 0, 0, 0, 1, 0, 0);

      // Straight-line fetch; start drops after the first edge
      cycle("t1_c0", 0, 1, 1, 0, 0, 0);
      chk("t1_valid_c1", {31'b0, if_id_valid_o}, 32'h1);
      for (int i = 0; i < 3; i++) cycle("t1", 0, 0, 1, 0, 0, 0);
      chk("t1_pc_const", pc_o, 32'h10);
      chk("t1_ifpc_const", if_id_pc_o, 32'hC);
      chk("t1_instr_const", if_id_instr_o, word_at(32'hC));

      // Load-use stall at pc=8, then split-stall variants
      cycle("t2_rst", 1, 0, 1, 0, 0, 0);
      cycle("t2_go", 0, 1, 1, 0, 0, 0);
      cycle("t2_f", 0, 0, 1, 0, 0, 0);
      cycle("t2_s0", 0, 0, 0, 1, 0, 0);
      cycle("t2_s1", 0, 0, 0, 1, 0, 0);
      chk("t2_pc_frozen", pc_o, 32'h8);
      chk("t2_stall_cnt_const", 32'(stall_count_o), 32'd2);
      cycle("t2_resume", 0, 0, 1, 0, 0, 0);
      chk("t2_pc_resume", pc_o, 32'hC);
      cycle("t2_split_a", 0, 0, 0, 0, 0, 0);
      cycle("t2_split_b", 0, 0, 1, 1, 0, 0);

      // Flush to 0x40 from pc=0x10
      cycle("t3_rst", 1, 0, 1, 0, 0, 0);
      cycle("t3_go", 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle("t3_f", 0, 0, 1, 0, 0, 0);
      cycle("t3_flush", 0, 0, 1, 0, 1, 32'h40);
      chk("t3_pc_const", pc_o, 32'h40);
      chk("t3_nop_const", if_id_instr_o, NOP);
      chk("t3_flush_cnt_const", 32'(flush_count_o), 32'd1);
      cycle("t3_after", 0, 0, 1, 0, 0, 0);
      chk("t3_instr_40", if_id_instr_o, word_at(32'h40));

      // Flush wins over a simultaneous stall; unaligned target
      cycle("t4_flush_stall", 0, 0, 0, 1, 1, 32'h23);
      chk("t4_pc_const", pc_o, 32'h20);
      chk("t4_stall_cnt_const", 32'(stall_count_o), 32'd0);

      // Counter saturation and PC wrap
      for (int i = 0; i < 9; i++) cycle("t5_stall", 0, 0, 0, 1, 0, 0);
      chk("t5_stall_sat_const", 32'(stall_count_o), 32'd7);
      for (int i = 0; i < 7; i++) cycle("t5_flush", 0, 0, 1, 0, 1, 32'hFFFF_FFFF);
      chk("t5_flush_sat_const", 32'(flush_count_o), 32'd7);
      chk("t5_pc_top", pc_o, 32'hFFFF_FFFC);
      cycle("t5_wrap", 0, 0, 1, 0, 0, 0);
      chk("t5_pc_wrap_const", pc_o, 32'h0);
      chk("t5_ifpc_top", if_id_pc_o, 32'hFFFF_FFFC);

      // Mid-run reset discards IF/ID; IDLE holds despite pc_write_i
      cycle("t6_f", 0, 0, 1, 0, 0, 0);
      cycle("t6_rst", 1, 0, 1, 0, 0, 0);
      chk("t6_valid_const", {31'b0, if_id_valid_o}, 32'h0);
      cycle("t6_idle_a", 0, 0, 1, 0, 0, 0);
      cycle("t6_idle_b", 0, 0, 1, 0, 0, 0);
      chk("t6_pc_hold_const", pc_o, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rnd",
               logic'($urandom_range(0, 39) == 0),
               logic'($urandom_range(0, 3) == 0),
               logic'($urandom_range(0, 4) != 0),
               logic'($urandom_range(0, 4) == 0),
               logic'($urandom_range(0, 6) == 0),
               $urandom());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
